jeff_tdm_demux8: RTL and testbench

- 1-line to 8-line time-division demultiplexer with frame sync: the receive-side counterpart of an 8:1 data selector that sends slots d0..d7 serially, one slot per clock.
- Tracks slot position with a 3-bit counter and sync flywheel, collects one full frame in a shadow register, then presents all 8 slots in parallel with a one-cycle frame_valid strobe.
- Sits between a serial TDM link and parallel consumer logic.

---
 rtl/jeff_tdm_demux8.sv | 148 ++++++++++++++
 tb/tb_jeff_tdm_demux8.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/jeff_tdm_demux8.sv
// 1-to-8 TDM demultiplexer with frame sync and miss-tolerant flywheel.
// Optional macro JEFF_TDM_DEMUX8_INV_EN adds output qn = ~q.
module jeff_tdm_demux8 #(
  parameter int DW         = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   din,
  input  logic            sync,
  input  logic            en_n,
  output logic [8*DW-1:0] q,
  output logic            frame_valid,
  output logic [2:0]      slot,
  output logic            locked,
  output logic            sync_err
`ifdef JEFF_TDM_DEMUX8_INV_EN
  ,
  output logic [8*DW-1:0] qn
`endif
);

  typedef enum logic [0:0] {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_next;
  logic [2:0]      slot_next;
  logic [2:0]      miss_cnt, miss_next;
  logic [7*DW-1:0] shadow, shadow_next;
  logic [8*DW-1:0] q_next;
  logic            fv_next, se_next, locked_next;
  logic            do_cap;
  logic [2:0]      wr_slot;
  logic            miss_ok;

  assign miss_ok = (({1'b0, miss_cnt} + 4'd1) < 4'(MISS_LIMIT));

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 3'd0;
      miss_cnt    <= 3'd0;
      shadow      <= '0;
      q           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_next;
      slot        <= slot_next;
      miss_cnt    <= miss_next;
      shadow      <= shadow_next;
      q           <= q_next;
      frame_valid <= fv_next;
      sync_err    <= se_next;
      locked      <= locked_next;
    end
  end

  // Next-state, capture decision and datapath update.
  always_comb begin
    state_next  = state;
    slot_next   = slot;
    miss_next   = miss_cnt;
    locked_next = locked;
    se_next     = 1'b0;
    fv_next     = 1'b0;
    do_cap      = 1'b0;
    wr_slot     = slot;
    shadow_next = shadow;
    q_next      = q;

    if (!en_n) begin
      case (state)
        HUNT: begin
          if (sync) begin
            do_cap      = 1'b1;
            wr_slot     = 3'd0;
            miss_next   = 3'd0;
            state_next  = LOCKED;
            locked_next = 1'b1;
          end else begin
            slot_next = 3'd0;
          end
        end
        LOCKED: begin
          if (sync && (slot != 3'd0)) begin
            // Resync: drop the partial frame and restart at slot 0.
            se_next   = 1'b1;
            do_cap    = 1'b1;
            wr_slot   = 3'd0;
            miss_next = 3'd0;
          end else if (!sync && (slot == 3'd0)) begin
            if (miss_ok) begin
              do_cap    = 1'b1;
              wr_slot   = 3'd0;
              miss_next = miss_cnt + 3'd1;
            end else begin
              state_next  = HUNT;
              locked_next = 1'b0;
              slot_next   = 3'd0;
              miss_next   = 3'd0;
            end
          end else begin
            do_cap  = 1'b1;
            wr_slot = slot;
            if (slot == 3'd0) begin
              miss_next = 3'd0;
            end else begin
              miss_next = miss_cnt;
            end
          end
        end
        default: begin
          state_next  = HUNT;
          locked_next = 1'b0;
          slot_next   = 3'd0;
          miss_next   = 3'd0;
        end
      endcase
    end else begin
      state_next = state;
    end

    if (do_cap) begin
      slot_next = wr_slot + 3'd1;
    end else begin
      slot_next = slot_next;
    end

    for (int k = 0; k < 7; k++) begin
      shadow_next[k*DW +: DW] = (do_cap && (wr_slot == 3'(k))) ? din : shadow[k*DW +: DW];
    end

    // Slot 7 completes the frame straight into q; it never touches the shadow.
    if (do_cap && (wr_slot == 3'd7)) begin
      q_next  = {din, shadow};
      fv_next = 1'b1;
    end else begin
      q_next = q;
    end
  end

`ifdef JEFF_TDM_DEMUX8_INV_EN
  assign qn = ~q;
`endif

endmodule

// File: tb/tb_jeff_tdm_demux8.sv
// Scoreboard bench for jeff_tdm_demux8 (DW=1, MISS_LIMIT=2).
module tb_jeff_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] din;
  logic       sync;
  logic       en_n;
  logic [7:0] q;
  logic       frame_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;
`ifdef JEFF_TDM_DEMUX8_INV_EN
  logic [7:0] qn;
`endif

  int checks = 0;
  int failures = 0;
  int se_count = 0;
  int cyc_cnt = 0;
  int last_fv = 0;
  int fv_gap = 0;
  logic prev_fv = 1'b0;
  logic [7:0] exp_q[$];

  jeff_tdm_demux8 #(.DW(1), .MISS_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .din(din), .sync(sync), .en_n(en_n),
    .q(q), .frame_valid(frame_valid), .slot(slot), .locked(locked),
    .sync_err(sync_err)
`ifdef JEFF_TDM_DEMUX8_INV_EN
    , .qn(qn)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare each delivered frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame actual=%0h required=none", q);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (q !== e) begin
            failures++;
            $display("FAIL frame_q actual=%0h required=%0h", q, e);
          end
        end
        fv_gap  = cyc_cnt - last_fv;
        last_fv = cyc_cnt;
      end
      if (sync_err) se_count++;
      if ((frame_valid && sync_err) || (frame_valid && prev_fv)) begin
        checks++;
        failures++;
        $display("FAIL pulse_rule actual=fv%0b_se%0b_prev%0b required=single", frame_valid, sync_err, prev_fv);
      end
      prev_fv = frame_valid;
    end
  end

  task automatic cyc(input logic d, input logic s, input logic e);
    din = d; sync = s; en_n = e;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic s0);
    exp_q.push_back(v);
    for (int k = 0; k < 8; k++) begin
      cyc(v[k], (k == 0) ? s0 : 1'b0, 1'b0);
      chk("slot_seq", 32'(slot), 32'((k + 1) % 8));
      chk("locked", 32'(locked), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1; din = 1'b0; sync = 1'b0; en_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_se", 32'(sync_err), 32'd0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("hunt_slot", 32'(slot), 32'd0);
    chk("hunt_locked", 32'(locked), 32'd0);

    send_frame(8'h4D, 1'b1);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    @(negedge clk); #1;
    chk("fv_gap", 32'(fv_gap), 32'd8);
    chk("q_3c", 32'(q), 32'h3C);
    chk("no_sync_err", 32'(se_count), 32'd0);

    // Resync at slot 4.
    for (int k = 0; k < 4; k++) cyc(1'b1, (k == 0), 1'b0);
    chk("pre_resync_slot", 32'(slot), 32'd4);
    v = 8'h5B;
    exp_q.push_back(v);
    cyc(v[0], 1'b1, 1'b0);
    chk("resync_se", 32'(sync_err), 32'd1);
    chk("resync_slot", 32'(slot), 32'd1);
    chk("resync_q_hold", 32'(q), 32'h3C);
    for (int k = 1; k < 8; k++) begin
      cyc(v[k], 1'b0, 1'b0);
      if (k == 1) chk("se_one_cycle", 32'(sync_err), 32'd0);
    end

    // Flywheel: first miss still captures, second drops lock.
    send_frame(8'h96, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("miss2_locked", 32'(locked), 32'd0);
    chk("miss2_slot", 32'(slot), 32'd0);
    repeat (3) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("hunt_hold_slot", 32'(slot), 32'd0);
    end
    chk("hunt_q_hold", 32'(q), 32'h96);

    // Relock, then stall 3 cycles at slot 3.
    send_frame(8'h4D, 1'b1);
    v = 8'hC3;
    exp_q.push_back(v);
    for (int k = 0; k < 3; k++) cyc(v[k], (k == 0), 1'b0);
    chk("pre_stall_slot", 32'(slot), 32'd3);
    repeat (3) begin
      cyc(1'b1, 1'b1, 1'b1);
      chk("stall_slot", 32'(slot), 32'd3);
      chk("stall_se", 32'(sync_err), 32'd0);
      chk("stall_fv", 32'(frame_valid), 32'd0);
    end
    for (int k = 3; k < 8; k++) cyc(v[k], 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("stall_q", 32'(q), 32'hC3);

    // Async reset at slot 5.
    for (int k = 0; k < 5; k++) cyc(1'b1, (k == 0), 1'b0);
    chk("pre_rst_slot", 32'(slot), 32'd5);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_slot", 32'(slot), 32'd0);
`ifdef JEFF_TDM_DEMUX8_INV_EN
    chk("arst_qn", 32'(qn), 32'hFF);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("arst_fv", 32'(frame_valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("se_total", 32'(se_count), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
